apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_if.sv | 70 +++++++
 rtl/apb_master.sv | 130 +++++++++++++
 tb/tb_apb_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and default parameters.
// Imported by the interface and the master itself so that both agree on default widths.
package apb_pkg;

    localparam int APB_DWIDTH  = 8;
    localparam int APB_AWIDTH  = 8;
    localparam int APB_TIMEOUT = 15;

    // Wide enough for the largest legal timeout (255).
    localparam int APB_WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Bundles the command/response handshake and the APB bus signals of the master.
// The master modport is the view seen by apb_master; the slave modport is the opposite side.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int DWIDTH = APB_DWIDTH,
    parameter int AWIDTH = APB_AWIDTH
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output rsp_timeout,
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA
    );

    modport slave (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        output PRDATA,
        output PREADY,
        output PSLVERR,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  rsp_timeout,
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA
    );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns one command into an IDLE/SETUP/ACCESS transfer
// and reports completion, slave error or wait-state timeout with a one-cycle response pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int DWIDTH  = APB_DWIDTH,
    parameter int AWIDTH  = APB_AWIDTH,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input logic         PCLK,
    input logic         PRESETn,
    apb_master_if.master bus
);

    localparam logic [APB_WAIT_CNT_W-1:0] TIMEOUT_CNT = APB_WAIT_CNT_W'(TIMEOUT);

    apb_state_e                state_q, state_d;
    logic [APB_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end

            ACCESS: begin
                // PREADY is checked first so a late ready still wins over the timeout.
                if (bus.PREADY) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        state_d       = IDLE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus strobes and cmd_ready are registered versions of the next state.
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master: one linear sequence of transfers, each
// followed cycle by cycle with immediate assertions against hand-computed values.
module tb_apb_master;

    logic PCLK;
    logic PRESETn;

    int n_checks;
    int n_fail;

    apb_master_if #(.DWIDTH(8), .AWIDTH(8)) bus ();

    apb_master #(
        .DWIDTH (8),
        .AWIDTH (8),
        .TIMEOUT(15)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = write;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    // PENABLE must never be seen without PSEL.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1) begin
            checkOutput("penable_implies_psel", {31'b0, bus.PENABLE & ~bus.PSEL}, 32'h0);
        end
    end

    initial begin
        logic [7:0] b2b_addr  [4];
        logic [7:0] b2b_wdata [4];
        b2b_addr  = '{8'h40, 8'h41, 8'h42, 8'h43};
        b2b_wdata = '{8'h11, 8'h22, 8'h33, 8'h44};

        n_checks      = 0;
        n_fail        = 0;
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.PRDATA    = 8'h00;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;

        // Reset state, with a command already pending that must wait for reset release.
        #2;
        applyStimulus(1'b1, 8'h04, 8'hA5);
        step();
        checkOutput("rst_psel", {31'b0, bus.PSEL}, 32'h0);
        checkOutput("rst_penable", {31'b0, bus.PENABLE}, 32'h0);
        checkOutput("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        checkOutput("rst_paddr", {24'b0, bus.PADDR}, 32'h0);
        checkOutput("rst_pwdata", {24'b0, bus.PWDATA}, 32'h0);
        checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        step();
        checkOutput("rst_hold_psel", {31'b0, bus.PSEL}, 32'h0);
        #4 PRESETn = 1'b1;

        // Zero-wait write 0xA5 to 0x04.
        step();
        bus.cmd_valid = 1'b0;
        checkOutput("wr_setup_psel", {31'b0, bus.PSEL}, 32'h1);
        checkOutput("wr_setup_penable", {31'b0, bus.PENABLE}, 32'h0);
        checkOutput("wr_setup_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
        checkOutput("wr_setup_pwrite", {31'b0, bus.PWRITE}, 32'h1);
        checkOutput("wr_setup_paddr", {24'b0, bus.PADDR}, 32'h04);
        checkOutput("wr_setup_pwdata", {24'b0, bus.PWDATA}, 32'hA5);
        step();
        checkOutput("wr_access_psel", {31'b0, bus.PSEL}, 32'h1);
        checkOutput("wr_access_penable", {31'b0, bus.PENABLE}, 32'h1);
        checkOutput("wr_access_pwdata", {24'b0, bus.PWDATA}, 32'hA5);
        checkOutput("wr_access_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        step();
        checkOutput("wr_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        checkOutput("wr_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
        checkOutput("wr_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'h0);
        checkOutput("wr_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'h0);
        checkOutput("wr_idle_psel", {31'b0, bus.PSEL}, 32'h0);
        checkOutput("wr_idle_penable", {31'b0, bus.PENABLE}, 32'h0);
        checkOutput("wr_idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        checkOutput("wr_idle_pwdata_hold", {24'b0, bus.PWDATA}, 32'hA5);
        step();
        checkOutput("wr_rsp_pulse_end", {31'b0, bus.rsp_valid}, 32'h0);

        // Read from 0x10 with three wait states, data 0x3C.
        applyStimulus(1'b0, 8'h10, 8'h00);
        bus.PREADY = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        checkOutput("rd_setup_pwrite", {31'b0, bus.PWRITE}, 32'h0);
        checkOutput("rd_setup_paddr", {24'b0, bus.PADDR}, 32'h10);
        step();
        checkOutput("rd_access_penable", {31'b0, bus.PENABLE}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rd_wait_penable", {31'b0, bus.PENABLE}, 32'h1);
            checkOutput("rd_wait_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        end
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h3C;
        step();
        checkOutput("rd_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        checkOutput("rd_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'h3C);
        checkOutput("rd_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
        checkOutput("rd_idle_psel", {31'b0, bus.PSEL}, 32'h0);
        bus.PRDATA = 8'h00;
        step();
        checkOutput("rd_rsp_pulse_end", {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput("rd_rsp_rdata_hold", {24'b0, bus.rsp_rdata}, 32'h3C);

        // Timeout: PREADY stays low for all 15 ACCESS cycles.
        applyStimulus(1'b0, 8'h20, 8'h00);
        bus.PREADY = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 14; i++) begin
            step();
            checkOutput("to_wait_penable", {31'b0, bus.PENABLE}, 32'h1);
            checkOutput("to_wait_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        end
        step();
        checkOutput("to_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        checkOutput("to_rsp_err", {31'b0, bus.rsp_err}, 32'h1);
        checkOutput("to_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'h1);
        checkOutput("to_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'h0);
        checkOutput("to_idle_psel", {31'b0, bus.PSEL}, 32'h0);
        checkOutput("to_idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        step();
        checkOutput("to_rsp_pulse_end", {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput("to_rsp_err_hold", {31'b0, bus.rsp_err}, 32'h1);

        // PREADY rising in the last allowed ACCESS cycle completes normally.
        applyStimulus(1'b0, 8'h21, 8'h00);
        step();
        bus.cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 14; i++) begin
            step();
        end
        checkOutput("late_still_access", {31'b0, bus.PENABLE}, 32'h1);
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h77;
        step();
        checkOutput("late_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        checkOutput("late_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
        checkOutput("late_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'h0);
        checkOutput("late_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'h77);

        // Write answered with PSLVERR.
        applyStimulus(1'b1, 8'h30, 8'h5C);
        bus.PSLVERR = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        checkOutput("slverr_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        checkOutput("slverr_rsp_err", {31'b0, bus.rsp_err}, 32'h1);
        checkOutput("slverr_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'h0);
        checkOutput("slverr_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'h0);
        bus.PSLVERR = 1'b0;

        // Back-to-back writes with cmd_valid held high.
        applyStimulus(1'b1, b2b_addr[0], b2b_wdata[0]);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("b2b_setup_paddr", {24'b0, bus.PADDR}, {24'b0, b2b_addr[i]});
            checkOutput("b2b_setup_pwdata", {24'b0, bus.PWDATA}, {24'b0, b2b_wdata[i]});
            checkOutput("b2b_setup_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
            checkOutput("b2b_setup_penable", {31'b0, bus.PENABLE}, 32'h0);
            if (i < 3) begin
                applyStimulus(1'b1, b2b_addr[i+1], b2b_wdata[i+1]);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            step();
            checkOutput("b2b_access_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
            checkOutput("b2b_access_penable", {31'b0, bus.PENABLE}, 32'h1);
            step();
            checkOutput("b2b_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
            checkOutput("b2b_idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        end

        // Asynchronous reset in the middle of ACCESS, then a normal read.
        applyStimulus(1'b0, 8'h50, 8'h00);
        bus.PREADY = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        checkOutput("mid_rst_in_access", {31'b0, bus.PENABLE}, 32'h1);
        #3 PRESETn = 1'b0;
        #1;
        checkOutput("mid_rst_psel", {31'b0, bus.PSEL}, 32'h0);
        checkOutput("mid_rst_penable", {31'b0, bus.PENABLE}, 32'h0);
        checkOutput("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        checkOutput("mid_rst_paddr", {24'b0, bus.PADDR}, 32'h0);
        checkOutput("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        step();
        checkOutput("mid_rst_hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        #4 PRESETn = 1'b1;
        applyStimulus(1'b0, 8'h60, 8'h00);
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h5A;
        step();
        bus.cmd_valid = 1'b0;
        checkOutput("post_rst_psel", {31'b0, bus.PSEL}, 32'h1);
        checkOutput("post_rst_paddr", {24'b0, bus.PADDR}, 32'h60);
        step();
        checkOutput("post_rst_rsp_early", {31'b0, bus.rsp_valid}, 32'h0);
        step();
        checkOutput("post_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        checkOutput("post_rst_rsp_rdata", {24'b0, bus.rsp_rdata}, 32'h5A);
        checkOutput("post_rst_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
